// File: rtl/esi_manifest_streamer.sv
// Holds a shadow snapshot of the compressed manifest and streams it on request as a header beat
// followed by the data beats. Define ESI_MANIFEST_DPI_EN to also forward changes over cosim DPI.
module esi_manifest_streamer #(
  parameter int unsigned COMPRESSED_MANIFEST_SIZE = 1,
  parameter int unsigned BEAT_BYTES               = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              compressed_manifest [0:COMPRESSED_MANIFEST_SIZE-1],
  input  logic                    req_valid,
  output logic                    req_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [8*BEAT_BYTES-1:0] out_data,
  output logic [BEAT_BYTES-1:0]   out_keep,
  output logic                    out_last,
  output logic                    manifest_changed,
  output logic [7:0]              manifest_version
);

  localparam int unsigned NumBeats  = (COMPRESSED_MANIFEST_SIZE + BEAT_BYTES - 1) / BEAT_BYTES;
  localparam int unsigned BeatW     = $clog2(NumBeats + 1);
  localparam int unsigned PadBytes  = NumBeats * BEAT_BYTES;
  localparam int unsigned LastBytes = COMPRESSED_MANIFEST_SIZE - (NumBeats - 1) * BEAT_BYTES;
  localparam logic [BEAT_BYTES-1:0] AllKeep  = '1;
  localparam logic [BEAT_BYTES-1:0] LastKeep = AllKeep >> (BEAT_BYTES - LastBytes);

  typedef enum logic [1:0] {StIdle, StHeader, StData} state_e;

  state_e             state_q, state_d;
  logic [BeatW-1:0]   beat_q, beat_d;
  logic [7:0]         shadow_q [0:COMPRESSED_MANIFEST_SIZE-1];
  logic [7:0]         shadow_d [0:COMPRESSED_MANIFEST_SIZE-1];
  logic [7:0]         version_q, version_d;
  logic               changed_q, changed_d;
  logic               manifest_diff;
  logic [8*PadBytes-1:0] padded;

  always_comb begin
    manifest_diff = 1'b0;
    for (int unsigned j = 0; j < COMPRESSED_MANIFEST_SIZE; j++) begin
      if (compressed_manifest[j] != shadow_q[j]) manifest_diff = 1'b1;
    end
  end

  // Snapshot zero-padded out to whole beats, so the tail of the last beat reads as zero.
  always_comb begin
    padded = '0;
    for (int unsigned j = 0; j < COMPRESSED_MANIFEST_SIZE; j++) begin
      padded[8*j +: 8] = shadow_q[j];
    end
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    shadow_d  = shadow_q;
    version_d = version_q;
    changed_d = 1'b0;
    req_ready = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_keep  = '0;
    out_last  = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_ready = rst_n;
        shadow_d  = compressed_manifest;
        if (manifest_diff) begin
          changed_d = 1'b1;
          version_d = version_q + 8'd1;
        end
        if (req_valid) state_d = StHeader;
      end
      StHeader: begin
        out_valid      = 1'b1;
        out_keep       = AllKeep;
        out_data[31:0] = {version_q, 24'(COMPRESSED_MANIFEST_SIZE)};
        if (out_ready) begin
          state_d = StData;
          beat_d  = '0;
        end
      end
      StData: begin
        out_valid = 1'b1;
        for (int unsigned b = 0; b < NumBeats; b++) begin
          if (beat_q == BeatW'(b)) out_data = padded[8*BEAT_BYTES*b +: 8*BEAT_BYTES];
        end
        if (beat_q == BeatW'(NumBeats - 1)) begin
          out_last = 1'b1;
          out_keep = LastKeep;
          if (out_ready) state_d = StIdle;
        end else begin
          out_keep = AllKeep;
          if (out_ready) beat_d = beat_q + BeatW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      beat_q    <= '0;
      shadow_q  <= '{default: 8'h00};
      version_q <= 8'h00;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      shadow_q  <= shadow_d;
      version_q <= version_d;
      changed_q <= changed_d;
    end
  end

  assign manifest_changed = changed_q;
  assign manifest_version = version_q;

`ifdef ESI_MANIFEST_DPI_EN
  import Cosim_DpiPkg::cosim_set_manifest;

  // Legacy delivery: one call per detected change, carrying the bytes being captured.
  always @(posedge clk) begin
    if (rst_n && changed_d) cosim_set_manifest(compressed_manifest);
  end
`endif

endmodule
